// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO
// registers. A launched operation takes 32 CALC cycles plus one SIGN cycle,
// and done pulses in the IDLE cycle that follows.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand magnitudes and one iteration of shift-add / restoring divide.
  // acc holds {P_hi, P_lo} for multiply and {remainder, dividend/quotient}
  // for divide; the multiply carry lands in bit 63 after the right shift.
  // A zero divisor needs no special iteration: every trial subtraction
  // succeeds, so the remainder ends up as |a| and re-signs back to raw a.
  always_comb begin
    op_signed = ~op[0];
    a_mag     = (op_signed && a[31]) ? -a : a;
    b_mag     = (op_signed && b[31]) ? -b : b;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
    prod      = neg_quo_q ? -acc_q : acc_q;
    quo       = div_zero_q ? '1 : (neg_quo_q ? -acc_q[31:0] : acc_q[31:0]);
    rem       = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
  end

  // Next-state logic: launch, iterate, sign-fix and HI/LO writes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          cnt_d      = 5'd31;
          is_div_d   = op[1];
          neg_quo_d  = op_signed & (a[31] ^ b[31]);
          neg_rem_d  = op_signed & a[31];
          div_zero_d = op[1] & (b == '0);
          opnd_d     = op[1] ? b_mag : a_mag;
          acc_d      = {32'd0, (op[1] ? a_mag : b_mag)};
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 5'd0) state_d = SIGN;
        else               cnt_d   = cnt_q - 5'd1;
      end
      SIGN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quo;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation in cycle 0 and watch cycles 1..40. mthi_at /
  // start_at inject a pulse in that cycle (-1 = none, 0 = with the launch).
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int mthi_at, input int start_at);
    int cyc, done_at, done_cnt;
    bit busy_ok, hold_ok;
    logic [31:0] hi0, lo0, hi34, lo34;
    hi0 = hi; lo0 = lo;
    hi34 = '0; lo34 = '0;
    busy_ok = 1'b1; hold_ok = 1'b1;
    done_at = -1; done_cnt = 0;
    start = 1'b1; op = o; a = xa; b = xb;
    mthi = (mthi_at == 0); wdata = 32'hDEADBEEF;
    step();
    cyc = 1;
    while (cyc <= 40) begin
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (cyc == 34) begin hi34 = hi; lo34 = lo; end
      if (cyc <= 33 && (!busy || hi !== hi0 || lo !== lo0)) begin
        if (!busy) busy_ok = 1'b0;
        else       hold_ok = 1'b0;
      end
      if (cyc >= 34 && busy) busy_ok = 1'b0;
      start = (cyc == start_at);
      mthi  = (cyc == mthi_at);
      a = $urandom; b = $urandom; op = 2'($urandom);
      step();
      cyc++;
    end
    check({tag, ".done_at"}, 64'(done_at), 64'd34);
    check({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, ".busy"}, 64'(busy_ok), 64'd1);
    check({tag, ".hold"}, 64'(hold_ok), 64'd1);
    check({tag, ".hi"}, 64'(hi34), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo34), 64'(exp_lo));
    check({tag, ".stable"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    step(); step();
    reset = 1'b0;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);

    // MTLO in IDLE lands at the next edge; HI untouched
    mtlo = 1'b1; wdata = 32'h0000_1234;
    step();
    mtlo = 1'b0;
    check("mtlo.lo", 64'(lo), 64'h1234);
    check("mtlo.hi", 64'(hi), 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, -1);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, -1);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         -1, -1);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
    run_op("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        -1, -1);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, -1, -1);
    run_op("divu_z",    2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, -1, -1);
    run_op("div_z",     2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, -1, -1);
    run_op("mthi_busy", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0,         10, -1);
    run_op("start_busy",2'b01, 32'd3,         32'd5,         32'h0,         32'd15,        -1, 5);
    run_op("start_mthi",2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        0,  -1);

    // reset in cycle 10 of a DIVU aborts it with no done pulse
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.hilo", {hi, lo}, 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      step();
    end
    check("abort.no_done", 64'(dn), 64'd0);
    run_op("after_rst", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
